// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: bit-serial D = X - Y - Bin, LSB first,
// one full-subtractor cell and a registered borrow, valid/ready on both sides.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (X, Y, Bin)
//   out_valid/out_ready     result handshake (D, Bout, V)
//   D                       difference modulo 2^WIDTH
//   Bout                    unsigned borrow-out (X < Y + Bin)
//   V                       signed two's-complement overflow
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;

    // Single full-subtractor cell on the current bit
    logic xi, yi, di, bnext;

    assign xi    = x_q[idx_q];
    assign yi    = y_q[idx_q];
    assign di    = xi ^ yi ^ borrow_q;
    assign bnext = (~xi & yi) | (~(xi ^ yi) & borrow_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        x_d      = x_q;
        y_d      = y_q;
        d_d      = d_q;
        bout_d   = bout_q;
        v_d      = v_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d      = X;
                    y_d      = Y;
                    borrow_d = Bin;
                    idx_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                d_d[idx_q] = di;
                borrow_d   = bnext;
                idx_d      = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    bout_d  = bnext;
                    // Operand signs differ and result sign left the minuend's
                    v_d     = (x_q[WIDTH-1] != y_q[WIDTH-1])
                            & (di != x_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign D         = d_q;
    assign Bout      = bout_q;
    assign V         = v_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor: vector table, handshake/reset sequences
// and an exhaustive sweep against an arithmetic reference model.
module tb_serial_borrow_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;

    int n_chk;
    int n_fail;

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         b;
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input int x, input int y, input int b,
                         output logic [W-1:0] d, output logic bo,
                         output logic v);
        int r;
        int sx;
        int sy;
        int sr;
        r  = x - y - b;
        d  = W'(r);
        bo = (r < 0);
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        sr = sx - sy - b;
        v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Entered and left on a negedge with the block idle
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic b, input int hold,
                          output logic [W-1:0] d, output logic bo,
                          output logic v, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        X        = x;
        Y        = y;
        Bin      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X        = W'($urandom);
        Y        = W'($urandom);
        Bin      = 1'($urandom);
        lat      = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        d  = D;
        bo = Bout;
        v  = V;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         bo;
        logic         v;
        logic [W-1:0] ed;
        logic         ebo;
        logic         ev;
        int           lat;
        int           guard;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Y         = '0;
        Bin       = 1'b0;

        tbl[0] = '{4'd9,  4'd5,  1'b0, 4'h4, 1'b0, 1'b1};
        tbl[1] = '{4'd3,  4'd5,  1'b0, 4'hE, 1'b1, 1'b0};
        tbl[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        tbl[3] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1};
        tbl[4] = '{4'd7,  4'd8,  1'b0, 4'hF, 1'b1, 1'b1};
        tbl[5] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[6] = '{4'd7,  4'd15, 1'b1, 4'h7, 1'b1, 1'b0};
        tbl[7] = '{4'd8,  4'd0,  1'b1, 4'h7, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_D", int'(D), 0);
        check("rst_Bout", int'(Bout), 0);
        check("rst_V", int'(V), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].b,
                   int'($urandom_range(0, 2)), d, bo, v, lat);
            check($sformatf("tbl%0d_D", i), int'(d), int'(tbl[i].d));
            check($sformatf("tbl%0d_Bout", i), int'(bo), int'(tbl[i].bo));
            check($sformatf("tbl%0d_V", i), int'(v), int'(tbl[i].v));
            check($sformatf("tbl%0d_lat", i), lat, W);
        end

        // Stall in DONE with in_valid held high
        X        = 4'd6;
        Y        = 4'd2;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        X = 4'd2;
        Y = 4'd1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        check("stall_lat", lat, W);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_out_valid", k), int'(out_valid), 1);
            check($sformatf("stall%0d_in_ready", k), int'(in_ready), 0);
            check($sformatf("stall%0d_D", k), int'(D), 4);
            check($sformatf("stall%0d_BV", k), int'({Bout, V}), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_idle_in_ready", int'(in_ready), 1);
        check("stall_idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_next_accepted", int'(in_ready), 0);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("stall_next_D", int'(D), 1);
        check("stall_next_BV", int'({Bout, V}), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset pulsed at the second SHIFT edge
        X        = 4'd1;
        Y        = 4'd0;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_D0", int'(D[0]), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_D", int'(D), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_BV", int'({Bout, V}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd15, 4'd15, 1'b0, 0, d, bo, v, lat);
        check("post_rst_D", int'(d), 0);
        check("post_rst_Bout", int'(bo), 0);
        check("post_rst_lat", lat, W);

        // Exhaustive sweep with random downstream stalls
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                for (int b = 0; b < 2; b++) begin
                    model(x, y, b, ed, ebo, ev);
                    run_op(W'(x), W'(y), 1'(b),
                           int'($urandom_range(0, 3)), d, bo, v, lat);
                    check($sformatf("sw_%0d_%0d_%0d_D", x, y, b),
                          int'(d), int'(ed));
                    check($sformatf("sw_%0d_%0d_%0d_Bout", x, y, b),
                          int'(bo), int'(ebo));
                    check($sformatf("sw_%0d_%0d_%0d_V", x, y, b),
                          int'(v), int'(ev));
                    check($sformatf("sw_%0d_%0d_%0d_lat", x, y, b),
                          lat, W);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
